// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: responder side of the CPU memory bus.
// Decodes the CPU address into mirrored work RAM, PPU register strobes and
// PRG ROM. It returns registered read data and runs the $4014 OAM DMA engine,
// which stalls the CPU through `halt` while it copies 256 bytes into OAM.
// Optional build macro: CPU_BUS_OPEN_BUS_EN. When it is defined, unmapped and
// $4014 reads return the last byte seen on the bus instead of 0x00.
module cpu_bus_responder #(
    parameter int RAM_ADDR_BITS   = 11,
    parameter int PRG_ADDR_BITS   = 15,
    parameter int DMA_START_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              mem_addr,
    input  logic [7:0]               mem_wdata,
    input  logic                     mem_write_en,
    input  logic                     mem_read_en,
    output logic [7:0]               mem_rdata,
    output logic                     halt,
    output logic [2:0]               ppu_reg_addr,
    output logic [7:0]               ppu_reg_wdata,
    output logic                     ppu_reg_we,
    output logic                     ppu_reg_re,
    input  logic [7:0]               ppu_reg_rdata,
    output logic [PRG_ADDR_BITS-1:0] prg_addr,
    input  logic [7:0]               prg_data,
    output logic [7:0]               oam_addr,
    output logic [7:0]               oam_wdata,
    output logic                     oam_we
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_WRITE
    } dma_state_t;

    // WAIT holds for DMA_START_DELAY cycles; the counter starts at delay-1.
    localparam logic [2:0] WAIT_INIT =
        (DMA_START_DELAY > 0) ? 3'(DMA_START_DELAY - 1) : 3'd0;

    logic [7:0] ram [0:(1 << RAM_ADDR_BITS) - 1];

    dma_state_t state;
    logic [7:0] dma_page;
    logic [7:0] dma_cnt;
    logic [2:0] wait_cnt;

    logic [15:0]              bus_addr;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic                     is_ram;
    logic                     is_ppu;
    logic                     is_prg;
    logic                     cpu_ram_we;
    logic [7:0]               rd_byte;
    logic [7:0]               open_byte;

    // While halted the DMA engine owns the decoder; the CPU bus is ignored.
    assign bus_addr = halt ? {dma_page, dma_cnt} : mem_addr;
    assign ram_idx  = bus_addr[RAM_ADDR_BITS-1:0];
    assign is_ram   = (bus_addr[15:13] == 3'b000);
    assign is_ppu   = (bus_addr[15:13] == 3'b001);
    assign is_prg   = bus_addr[15];

    assign prg_addr = bus_addr[PRG_ADDR_BITS-1:0];

    // PPU strobes are combinational so the PPU answers within the same cycle.
    // A simultaneous write and read strobe counts as a write only.
    assign ppu_reg_we    = !rst && !halt && mem_write_en && is_ppu;
    assign ppu_reg_re    = !rst && !halt && mem_read_en && !mem_write_en && is_ppu;
    assign ppu_reg_addr  = rst ? 3'd0 : bus_addr[2:0];
    assign ppu_reg_wdata = rst ? 8'h00 : mem_wdata;

    assign cpu_ram_we = !rst && !halt && mem_write_en && is_ram;

`ifdef CPU_BUS_OPEN_BUS_EN
    logic [7:0] cpu_last;
    logic [7:0] dma_last;

    // Track the last byte moved on the CPU bus and on the DMA path separately.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_last <= 8'h00;
            dma_last <= 8'h00;
        end else if (!halt) begin
            cpu_last <= mem_write_en ? mem_wdata : rd_byte;
        end else if (state == S_READ) begin
            dma_last <= rd_byte;
        end
    end

    assign open_byte = halt ? dma_last : cpu_last;
`else
    assign open_byte = 8'h00;
`endif

    // Read source mux shared by CPU reads and DMA reads.
    always_comb begin
        rd_byte = open_byte;
        if (is_ram) begin
            rd_byte = ram[ram_idx];
        end else if (is_ppu) begin
            rd_byte = ppu_reg_rdata;
        end else if (is_prg) begin
            rd_byte = prg_data;
        end
    end

    // Work RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (cpu_ram_we) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

    // Read data follows the sampled address every cycle and freezes during DMA.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata <= 8'h00;
        end else if (!halt) begin
            mem_rdata <= rd_byte;
        end
    end

    // OAM DMA engine: one READ and one WRITE cycle per byte, 256 bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            halt      <= 1'b0;
            dma_page  <= 8'h00;
            dma_cnt   <= 8'h00;
            wait_cnt  <= 3'd0;
            oam_we    <= 1'b0;
            oam_addr  <= 8'h00;
            oam_wdata <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    oam_we <= 1'b0;
                    if (mem_write_en && (mem_addr == 16'h4014)) begin
                        dma_page <= mem_wdata;
                        dma_cnt  <= 8'h00;
                        wait_cnt <= WAIT_INIT;
                        halt     <= 1'b1;
                        state    <= (DMA_START_DELAY == 0) ? S_READ : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= S_READ;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_READ: begin
                    oam_we    <= 1'b1;
                    oam_addr  <= dma_cnt;
                    oam_wdata <= rd_byte;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    oam_we <= 1'b0;
                    if (dma_cnt == 8'hFF) begin
                        halt  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        dma_cnt <= dma_cnt + 8'd1;
                        state   <= S_READ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Testbench for cpu_bus_responder: directed test-plan sequences plus random
// bus traffic, checked every cycle against a transaction-level model.
module tb_cpu_bus_responder;

    localparam int D = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [7:0]  mem_rdata;
    logic        halt;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_reg_wdata;
    logic        ppu_reg_we;
    logic        ppu_reg_re;
    logic [7:0]  ppu_reg_rdata;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit rdata_chk = 0;

    always #5 clk = ~clk;

    // Peripheral models: PRG returns the low address byte, PPU a fixed pattern.
    assign prg_data      = prg_addr[7:0];
    assign ppu_reg_rdata = 8'hC0 ^ {5'd0, ppu_reg_addr};

    cpu_bus_responder #(
        .RAM_ADDR_BITS  (11),
        .PRG_ADDR_BITS  (15),
        .DMA_START_DELAY(D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_rdata    (mem_rdata),
        .halt         (halt),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_reg_wdata(ppu_reg_wdata),
        .ppu_reg_we   (ppu_reg_we),
        .ppu_reg_re   (ppu_reg_re),
        .ppu_reg_rdata(ppu_reg_rdata),
        .prg_addr     (prg_addr),
        .prg_data     (prg_data),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_we       (oam_we)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ram_m [0:2047];
    bit         run_m = 0;
    int         k_m = 0;
    bit         halted_m;
    int         j_m;
    logic [7:0] page_m = 8'h00;
    logic [7:0] cpu_last_m = 8'h00;
    logic [7:0] dma_last_m = 8'h00;
    logic [7:0] nb_m;
    logic [7:0] exp_rdata = 8'h00;
    bit         exp_halt = 0;
    bit         exp_oam_we = 0;
    logic [7:0] exp_oam_addr = 8'h00;
    logic [7:0] exp_oam_data = 8'h00;

    function automatic logic [7:0] src(input logic [15:0] a, input logic [7:0] openv);
        if (a[15:13] == 3'b000) return ram_m[a[10:0]];
        if (a[15:13] == 3'b001) return 8'hC0 ^ {5'd0, a[2:0]};
        if (a[15]) return a[7:0];
        return openv;
    endfunction

    function automatic logic [7:0] cpu_open();
`ifdef CPU_BUS_OPEN_BUS_EN
        return cpu_last_m;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] dma_open();
`ifdef CPU_BUS_OPEN_BUS_EN
        return dma_last_m;
`else
        return 8'h00;
`endif
    endfunction

    // k_m numbers the cycles after the $4014 write: halt covers 1..D+512, byte j
    // is read in cycle D+1+2j and written to OAM in cycle D+2+2j.
    always @(posedge clk) begin
        if (rst) begin
            run_m = 0; k_m = 0; exp_rdata = 8'h00;
            cpu_last_m = 8'h00; dma_last_m = 8'h00;
            exp_oam_we = 0; exp_oam_addr = 8'h00; exp_oam_data = 8'h00;
        end else begin
            halted_m = run_m;
            if (run_m && k_m >= D + 1 && ((k_m - D - 1) % 2 == 0)) begin
                j_m = (k_m - D - 1) / 2;
                nb_m = src({page_m, 8'(j_m)}, dma_open());
                dma_last_m = nb_m;
                exp_oam_we = 1; exp_oam_addr = 8'(j_m); exp_oam_data = nb_m;
            end else begin
                exp_oam_we = 0;
            end
            if (!halted_m) begin
                nb_m = src(mem_addr, cpu_open());
                exp_rdata = nb_m;
                cpu_last_m = mem_write_en ? mem_wdata : nb_m;
                if (mem_write_en && mem_addr[15:13] == 3'b000) ram_m[mem_addr[10:0]] = mem_wdata;
            end
            if (run_m) begin
                k_m++;
                if (k_m > D + 512) run_m = 0;
            end
            if (!halted_m && mem_write_en && mem_addr == 16'h4014) begin
                run_m = 1; k_m = 1; page_m = mem_wdata;
            end
        end
        exp_halt = run_m;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit ppu_hit = (mem_addr[15:13] == 3'b001);
            automatic bit e_we = !rst && !exp_halt && mem_write_en && ppu_hit;
            automatic bit e_re = !rst && !exp_halt && mem_read_en && !mem_write_en && ppu_hit;
            if (rdata_chk) chk("mem_rdata", 32'(mem_rdata), 32'(exp_rdata));
            chk("halt", 32'(halt), 32'(exp_halt));
            chk("oam_we", 32'(oam_we), 32'(exp_oam_we));
            if (exp_oam_we) begin
                chk("oam_addr", 32'(oam_addr), 32'(exp_oam_addr));
                chk("oam_wdata", 32'(oam_wdata), 32'(exp_oam_data));
            end
            chk("ppu_reg_we", 32'(ppu_reg_we), 32'(e_we));
            chk("ppu_reg_re", 32'(ppu_reg_re), 32'(e_re));
            if (e_we || e_re) chk("ppu_reg_addr", 32'(ppu_reg_addr), 32'(mem_addr[2:0]));
            if (e_we) chk("ppu_reg_wdata", 32'(ppu_reg_wdata), 32'(mem_wdata));
            if (!exp_halt && !rst) chk("prg_addr", 32'(prg_addr), 32'(mem_addr[14:0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        mem_addr = a; mem_wdata = d; mem_write_en = w; mem_read_en = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        drive(a, d, w, r);
        step();
    endtask

    task automatic idle();
        drive(16'h5000, 8'h00, 1'b0, 1'b0);
    endtask

    // Start a DMA, drive random junk on the halted bus, stop at the end or after
    // stop_after OAM pulses (0 = run to completion).
    task automatic run_dma(input logic [7:0] page, input int stop_after,
                           output int halt_cycles, output int pulses);
        int c;
        drive(16'h4014, page, 1'b1, 1'b0);
        #1;
        chk("halt_before_edge", 32'(halt), 32'd0);
        step();
        chk("halt_first_cycle", 32'(halt), 32'd1);
        halt_cycles = 0; pulses = 0; c = 0;
        while (halt && c < 700) begin
            halt_cycles++;
            if (oam_we) begin
                pulses++;
                chk("oam_addr_seq", 32'(oam_addr), 32'(pulses - 1));
                if (page == 8'h02) chk("oam_data_02", 32'(oam_wdata), 32'(8'(pulses - 1) ^ 8'h5A));
                if (stop_after != 0 && pulses == stop_after) return;
            end
            drive(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            step();
            c++;
        end
        if (c >= 700) chk("dma_timeout", 32'd1, 32'd0);
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hc, pc;
        logic [15:0] a;
        logic w, r;

        rst = 1'b1;
        idle();
        step();
        chk_en = 1;
        step();
        chk("rst_mem_rdata", 32'(mem_rdata), 32'h00);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_oam_addr", 32'(oam_addr), 32'h00);
        chk("rst_oam_wdata", 32'(oam_wdata), 32'h00);
        chk("rst_ppu_we", 32'(ppu_reg_we), 32'd0);
        chk("rst_ppu_re", 32'(ppu_reg_re), 32'd0);
        chk("rst_ppu_addr", 32'(ppu_reg_addr), 32'd0);
        chk("rst_ppu_wdata", 32'(ppu_reg_wdata), 32'h00);
        rst = 1'b0;

        // Preload all of RAM, then the DMA pattern page.
        for (int i = 0; i < 2048; i++) bus(16'(i), 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) bus(16'(16'h0200 + i), 8'(i) ^ 8'h5A, 1'b1, 1'b0);
        bus(16'h5000, 8'h00, 1'b0, 1'b1);
        rdata_chk = 1;

        // RAM mirroring.
        bus(16'h0005, 8'hA5, 1'b1, 1'b0);
        bus(16'h0805, 8'h00, 1'b0, 1'b1);
        chk("ram_mirror_0805", 32'(mem_rdata), 32'hA5);
        bus(16'h1805, 8'h00, 1'b0, 1'b1);
        chk("ram_mirror_1805", 32'(mem_rdata), 32'hA5);

        // PPU write pulse.
        drive(16'h2001, 8'h1E, 1'b1, 1'b0);
        #1;
        chk("ppu_we_pulse", 32'(ppu_reg_we), 32'd1);
        chk("ppu_we_addr", 32'(ppu_reg_addr), 32'd1);
        chk("ppu_we_data", 32'(ppu_reg_wdata), 32'h1E);
        step();
        idle();
        #1;
        chk("ppu_we_single", 32'(ppu_reg_we), 32'd0);

        // PPU read with and without strobe.
        drive(16'h3FFA, 8'h00, 1'b0, 1'b1);
        #1;
        chk("ppu_re_pulse", 32'(ppu_reg_re), 32'd1);
        chk("ppu_re_addr", 32'(ppu_reg_addr), 32'd2);
        step();
        chk("ppu_rdata", 32'(mem_rdata), 32'hC2);
        drive(16'h2003, 8'h00, 1'b0, 1'b0);
        #1;
        chk("ppu_no_strobe", 32'(ppu_reg_re), 32'd0);
        step();
        chk("ppu_rdata_nostrobe", 32'(mem_rdata), 32'hC3);

        // Write and read strobes together: write wins.
        drive(16'h2005, 8'h09, 1'b1, 1'b1);
        #1;
        chk("ppu_both_re", 32'(ppu_reg_re), 32'd0);
        chk("ppu_both_we", 32'(ppu_reg_we), 32'd1);
        step();

        // PRG reads; PRG writes ignored.
        drive(16'hFFFC, 8'h00, 1'b0, 1'b1);
        #1;
        chk("prg_addr_fffc", 32'(prg_addr), 32'h7FFC);
        step();
        chk("prg_rdata_fffc", 32'(mem_rdata), 32'hFC);
        bus(16'h8000, 8'h77, 1'b1, 1'b0);
        bus(16'h8000, 8'h00, 1'b0, 1'b1);
        chk("prg_write_ignored", 32'(mem_rdata), 32'h00);

        // Full DMA from RAM page 2.
        run_dma(8'h02, 0, hc, pc);
        chk("dma_halt_cycles", 32'(hc), 32'(D + 512));
        chk("dma_pulses", 32'(pc), 32'd256);
        bus(16'h0200, 8'h00, 1'b0, 1'b1);
        chk("ram_after_dma_0200", 32'(mem_rdata), 32'h5A);
        bus(16'h02FF, 8'h00, 1'b0, 1'b1);
        chk("ram_after_dma_02ff", 32'(mem_rdata), 32'hA5);

        // Reset in the middle of a DMA.
        run_dma(8'h02, 100, hc, pc);
        chk("mid_dma_pulses", 32'(pc), 32'd100);
        rst = 1'b1;
        idle();
        step();
        chk("abort_halt", 32'(halt), 32'd0);
        chk("abort_oam_we", 32'(oam_we), 32'd0);
        rst = 1'b0;
        bus(16'h0263, 8'h00, 1'b0, 1'b1);
        chk("ram_kept_after_abort", 32'(mem_rdata), 32'h39);
        run_dma(8'h07, 0, hc, pc);
        chk("restart_pulses", 32'(pc), 32'd256);

        // DMA from PRG, PPU and unmapped/$4014 pages.
        run_dma(8'h80, 0, hc, pc);
        run_dma(8'h21, 0, hc, pc);
        run_dma(8'h40, 0, hc, pc);
        chk("dma_40_halt_cycles", 32'(hc), 32'(D + 512));

        // Open bus vs zero for unmapped reads.
        bus(16'h0010, 8'h3C, 1'b1, 1'b0);
        bus(16'h0010, 8'h00, 1'b0, 1'b1);
        chk("read_3c", 32'(mem_rdata), 32'h3C);
        bus(16'h5000, 8'h00, 1'b0, 1'b1);
`ifdef CPU_BUS_OPEN_BUS_EN
        chk("unmapped_read", 32'(mem_rdata), 32'h3C);
`else
        chk("unmapped_read", 32'(mem_rdata), 32'h00);
`endif

        // Random traffic with occasional DMA triggers.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0: a = 16'($urandom_range(0, 16'h1FFF));
                1: a = 16'($urandom_range(16'h2000, 16'h3FFF));
                2: a = 16'($urandom_range(16'h8000, 16'hFFFF));
                3: a = 16'($urandom_range(16'h4000, 16'h7FFF));
                default: a = 16'h4014;
            endcase
            w = ($urandom_range(0, 3) == 0);
            r = 1'($urandom_range(0, 1));
            if (a == 16'h4014 && $urandom_range(0, 9) != 0) w = 1'b0;
            bus(a, 8'($urandom), w, r);
        end
        idle();
        for (int n = 0; n < 600 && halt; n++) step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Responder side of the CPU memory bus driven by the execution engine. Decodes `mem_addr` into three targets: internal 2 KB work RAM (mirrored), PPU register strobes ($2000-$3FFF), and the external PRG ROM ($8000-$FFFF).
- Returns registered read data to the CPU.
- Hosts the OAM DMA engine triggered by writes to $4014. It holds the CPU in `halt` while copying 256 bytes into PPU OAM.

Parameters:
- RAM_ADDR_BITS, 11, log2 of work RAM size; $0000-$1FFF mirrors it.
- PRG_ADDR_BITS, 15, width of `prg_addr`; $8000-$FFFF maps to PRG offset `mem_addr[PRG_ADDR_BITS-1:0]`.
- DMA_START_DELAY, 1, cycles from the accepted $4014 write to the first DMA read; must be ≤ 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_addr  in  16  CPU bus address
- mem_wdata  in  8  CPU write data
- mem_write_en  in  1  CPU write strobe, one cycle per write
- mem_read_en  in  1  CPU read strobe; qualifies side-effect reads only
- mem_rdata  out  8  registered read data to CPU
- halt  out  1  stalls CPU while DMA is active
- ppu_reg_addr  out  3  PPU register index
- ppu_reg_wdata  out  8  PPU register write data
- ppu_reg_we  out  1  PPU register write pulse
- ppu_reg_re  out  1  PPU register read pulse
- ppu_reg_rdata  in  8  PPU register read data, valid in the same cycle as `ppu_reg_re`
- prg_addr  out  PRG_ADDR_BITS  PRG ROM address (combinational)
- prg_data  in  8  PRG ROM data, valid in the same cycle as `prg_addr`
- oam_addr  out  8  OAM write address
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write pulse

Behaviour:
- Reset values:
  - `mem_rdata` = 0x00, `halt` = 0.
  - `ppu_reg_we`, `ppu_reg_re`, `oam_we` = 0.
  - `oam_addr`, `ppu_reg_addr`, `ppu_reg_wdata`, `oam_wdata` = 0.
  - DMA state machine in IDLE, byte counter = 0.
- Decode from the CPU address when not halted, or from the DMA address when halted:
  - RAM: addr[15:13] == 000, index `addr[RAM_ADDR_BITS-1:0]`.
  - PPU: addr[15:13] == 001, index `addr[2:0]`.
  - DMA register: addr == $4014.
  - PRG: addr[15] == 1.
  - Everything else is unmapped.
- Read timing:
  - `mem_rdata` updates on every rising edge from the address sampled at that edge, regardless of `mem_read_en`.
  - Data is therefore valid one cycle after the address is presented. The CPU's stack pulls rely on this without asserting a read strobe.
- Read sources:
  - RAM: stored byte.
  - PRG: `prg_data`.
  - PPU: `ppu_reg_rdata`.
  - Unmapped and $4014: 0x00.
- PPU read strobe:
  - `ppu_reg_re` pulses combinationally for the cycle in which `mem_read_en` = 1, `mem_write_en` = 0 and the address decodes to PPU.
  - A PPU read without `mem_read_en` returns data but raises no strobe.
- Writes:
  - RAM: written at the edge where `mem_write_en` = 1.
  - PPU: `ppu_reg_we` pulses that cycle, with `ppu_reg_addr` = addr[2:0] and `ppu_reg_wdata` = `mem_wdata`.
  - PRG and unmapped: writes ignored.
  - Write and read strobes asserted together: the write wins and `ppu_reg_re` = 0.
- DMA state machine (IDLE → WAIT → READ → WRITE → … → IDLE):
  - IDLE: a CPU write to $4014 latches page P = `mem_wdata`, clears the counter and goes to WAIT.
  - WAIT: counts DMA_START_DELAY cycles. `halt` is asserted from the first WAIT cycle (registered, 1 cycle after the write). Then goes to READ.
  - READ: presents source address {P, cnt} to the internal decoder. The CPU bus is ignored while `halt` = 1. Goes to WRITE.
  - WRITE: `oam_we` = 1 for one cycle, `oam_addr` = cnt, `oam_wdata` = byte read from {P, cnt}.
    - cnt == 255: go to IDLE and drop `halt` at that edge.
    - Otherwise: cnt increments and the state returns to READ.
  - Total `halt` duration = DMA_START_DELAY + 512 cycles.
- DMA source rules:
  - Source pages decode exactly like CPU reads: RAM pages mirror, PPU pages return `ppu_reg_rdata` with no strobe, unmapped pages give 0x00.
  - `mem_rdata` keeps its last CPU value while halted.
- Boundary conditions:
  - A $4014 write while DMA is active is impossible (CPU halted) and is ignored.
  - Counter wrap from 255 ends the transfer; `oam_addr` never exceeds 255.
  - Reset mid-DMA aborts immediately: `halt` = 0, `oam_we` = 0, state IDLE. RAM contents are not cleared.

Optional Feature:
- Macro: CPU_BUS_OPEN_BUS_EN.
- Defined: unmapped and $4014 reads return the last byte transferred on the CPU bus, i.e. the previous `mem_rdata` or the most recent `mem_wdata`, whichever is later. DMA unmapped reads return the last DMA byte.
- Undefined: these reads return 0x00.

Test Plan:
- Write 0xA5 to $0005, then read $0805 and $1805 → `mem_rdata` = 0xA5 one cycle after each address.
- Write 0x1E to $2001 → single-cycle `ppu_reg_we`, `ppu_reg_addr` = 1, `ppu_reg_wdata` = 0x1E. Read $3FFA with `mem_read_en` → `ppu_reg_re` pulse, `ppu_reg_addr` = 2, `mem_rdata` = `ppu_reg_rdata` next cycle.
- `prg_data` model returns the low address byte; read $FFFC → `prg_addr` = 0x7FFC, `mem_rdata` = 0xFC. Write to $8000 → no effect.
- RAM $0200-$02FF preloaded with i^0x5A; write 0x02 to $4014 → `halt` rises 1 cycle later, 256 `oam_we` pulses with `oam_addr` 0..255 and data i^0x5A, `halt` falls after exactly 513 cycles.
- Assert `rst` after 100 DMA bytes → `halt` and `oam_we` are 0 the next cycle, RAM intact. A new $4014 write restarts at `oam_addr` 0.
- Read $5000 after a read returning 0x3C → 0x00 without CPU_BUS_OPEN_BUS_EN, 0x3C with it.
